clmul_xor_acc: RTL
==================

// Module: clmul_xor_acc
// PURPOSE
//  Downstream consumer of the 8-bit truncated carry-less (GF(2)) multiplier stage.
//  Accepts one product word per cycle over valid/ready and XOR-accumulates a frame of
//  products. This forms a GF(2) dot product, sum(a_i*b_i) mod x^8.
//  Emits one result word per frame over valid/ready, with frame id and short-frame flag.
// PARAMETERS
//  W      8   product/result word width (matches multiplier output y[7:0])
//  LEN_W  8   width of frame-length config; frame length range 1..2^LEN_W
//  ID_W   4   width of frame id counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous reset, active-high
//  cfg_len    in   LEN_W  frame length in beats; 0 means 2^LEN_W; sampled on first beat only
//  in_valid   in   1      product word valid
//  in_ready   out  1      block can accept a product word
//  in_data    in   W      product word from carry-less multiplier
//  in_last    in   1      force end of frame on this beat (early termination)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  W      XOR of all beats of the frame
//  out_short  out  1      frame ended by in_last before cfg_len beats
//  out_id     out  ID_W   frame id, increments per emitted result, wraps mod 2^ID_W
// BEHAVIOUR
//  Reset (async, any time):
//   - state=IDLE, acc=0, beat_cnt=0.
//   - out_valid=0, out_data=0, out_short=0, out_id=0.
//   - in_ready=1 one cycle after reset deasserts.
//   - A partial frame is discarded and no result is emitted.
//  Beat accepted when in_valid && in_ready.
//  in_ready = (state != HOLD), purely combinational from state.
//  States:
//   IDLE: on beat, capture len = (cfg_len==0 ? 2^LEN_W : cfg_len), acc=in_data, beat_cnt=1.
//    - If len==1 or in_last: go to HOLD.
//    - Otherwise go to ACC.
//   ACC: on beat, acc ^= in_data and beat_cnt++.
//    - Go to HOLD when beat_cnt+1 == len or in_last.
//    - Otherwise stay in ACC, including on cycles with no beat (no timeout).
//   HOLD: out_valid=1 with the result registered on entry.
//    - out_data = final acc.
//    - out_short=1 iff in_last ended the frame at beat count < len.
//    - in_last on exactly the len-th beat: out_short=0.
//    - out_data, out_short, out_id stay stable while out_valid && !out_ready.
//    - On out_valid && out_ready: out_valid=0, out_id++, go to IDLE.
//  Latency:
//   - out_valid rises the cycle after the final beat is accepted.
//   - Minimum gap between frames is 1 bubble cycle: the HOLD cycle has in_ready=0.
//  Width rules:
//   - XOR only, no carries, no reduction; out_data is exactly W bits.
//   - beat_cnt is LEN_W+1 bits so that len=2^LEN_W is representable.
//  Boundary conditions:
//   - cfg_len changes mid-frame are ignored.
//   - in_data/in_last are ignored when in_valid=0 or in_ready=0.
//   - out_id wraps 2^ID_W-1 -> 0.
//   - out_data goes to 0 when leaving HOLD; it is don't-care but held 0 for determinism.
//  Next frame:
//   - The first beat of the next frame is accepted no earlier than the cycle after the
//     output handshake (HOLD->IDLE).
//   - in_ready is 1 in IDLE.
// TESTING
//  1. cfg_len=3, beats 0x0F,0xF0,0x3C back-to-back, out_ready=1
//     -> out_data=0xC3, out_short=0, out_id=0, out_valid 1 cycle after beat 3.
//  2. Hold out_ready=0 for 5 cycles in HOLD
//     -> in_ready=0, out_data/out_id stable, single handshake; next result has out_id=1.
//  3. cfg_len=5, beats 0xAA,0x55 with in_last on beat 2 -> out_data=0xFF, out_short=1.
//  4. cfg_len=0, 256 beats of 0x01
//     -> out_data=0x00 after beat 256, no result earlier; with 255 beats, no out_valid.
//  5. cfg_len=1, beat 0x5A -> out_data=0x5A next cycle; repeat 17 frames -> out_id wraps to 0.
//  6. Assert rst mid-frame after 2 beats, then run frame cfg_len=2, 0x11,0x22
//     -> no stale result, out_data=0x33, out_id=0.

Source files
------------

// File: rtl/clmul_xor_acc.sv
// ---------------------------------------------------------------------------
// clmul_xor_acc
//
// Sits downstream of the 8-bit truncated carry-less multiplier. Each accepted
// product word is XOR-accumulated into a running frame sum, which gives a
// GF(2) dot product sum(a_i*b_i) mod x^8. One result word is emitted per frame.
//
// A frame ends when either:
//   - the configured number of beats has been accepted, or
//   - a beat arrives with in_last set, which ends the frame early.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active-high
//   cfg_len    frame length in beats (0 means 2^LEN_W), sampled on first beat
//   in_valid   product word valid
//   in_ready   block can accept a product word (low only while a result is held)
//   in_data    product word from the carry-less multiplier
//   in_last    end the frame on this beat
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   XOR of all beats of the frame
//   out_short  frame was ended by in_last before cfg_len beats
//   out_id     frame id, increments per emitted result and wraps
// ---------------------------------------------------------------------------
module clmul_xor_acc #(
    parameter int W     = 8,
    parameter int LEN_W = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_short,
    output logic [ID_W-1:0]  out_id
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    // Length and beat counter carry one extra bit so that a full 2^LEN_W
    // frame (cfg_len == 0) can be represented and compared directly.
    localparam logic [LEN_W:0] ONE     = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] MAX_LEN = {1'b1, {LEN_W{1'b0}}};

    state_t         state;
    logic [LEN_W:0] len;
    logic [LEN_W:0] beat_cnt;
    logic [W-1:0]   acc;

    logic           beat;
    logic [LEN_W:0] first_len;
    logic [LEN_W:0] next_cnt;
    logic [W-1:0]   acc_next;

    // Handshake and next-value helpers. The upstream is only stalled while a
    // finished result is waiting for the downstream to take it.
    always_comb begin
        in_ready  = (state != HOLD);
        beat      = in_valid && in_ready;
        first_len = (cfg_len == '0) ? MAX_LEN : {1'b0, cfg_len};
        next_cnt  = beat_cnt + ONE;
        acc_next  = acc ^ in_data;
    end

    // Frame sequencer. The result registers are loaded on the same edge that
    // accepts the final beat, so out_valid rises the cycle after that beat.
    // out_short is set only when in_last arrives before the configured length;
    // in_last on exactly the last beat is a normal frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            beat_cnt  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_short <= 1'b0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        len      <= first_len;
                        acc      <= in_data;
                        beat_cnt <= ONE;
                        if ((first_len == ONE) || in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_short <= (first_len != ONE);
                        end else begin
                            state <= ACC;
                        end
                    end
                end

                ACC: begin
                    if (beat) begin
                        acc      <= acc_next;
                        beat_cnt <= next_cnt;
                        if ((next_cnt == len) || in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_data  <= acc_next;
                            out_short <= (next_cnt != len);
                        end
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_short <= 1'b0;
                        out_id    <= out_id + ID_W'(1);
                        acc       <= '0;
                        beat_cnt  <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
